pipeline_hazard_ctrl: RTL and testbench

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 24 ++
 rtl/pipeline_hazard_ctrl_hazard_detect.sv | 20 ++
 rtl/pipeline_hazard_ctrl.sv | 159 +++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared core header: pipeline op-width constants plus the hazard-controller state encoding.
package pipeline_hazard_ctrl_pkg;

    localparam int OP_W       = 6;
    localparam int FUNCT_W    = 6;
    localparam int REG_ADDR_W = 5;
    localparam int STATE_W    = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_HALT     = 2'd2,
        ST_BAD      = 2'd3
    } state_e;

    function automatic logic src_match(
        input logic                  use_src,
        input logic [REG_ADDR_W-1:0] src,
        input logic [REG_ADDR_W-1:0] dst
    );
        return use_src & (src == dst);
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Pure combinational load-use detector: an EX load whose non-zero destination feeds an ID source.
module hazard_detect
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] regfile_req_a_id,
    input  logic [REG_ADDR_W-1:0] regfile_req_b_id,
    input  logic                  use_a_id,
    input  logic                  use_b_id,
    input  logic [REG_ADDR_W-1:0] regfile_req_w_id_ex,
    input  logic                  memtoreg_id_ex,
    output logic                  o_hazard
);

    // r0 is hard-wired zero, so a load targeting it never creates a dependency
    assign o_hazard = memtoreg_id_ex
                    & (regfile_req_w_id_ex != {REG_ADDR_W{1'b0}})
                    & (src_match(use_a_id, regfile_req_a_id, regfile_req_w_id_ex)
                     | src_match(use_b_id, regfile_req_b_id, regfile_req_w_id_ex));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: Mealy FSM (RUN/MEM_WAIT/HALT) driving stage enables and flushes.
// Optional statistics counters are built only when PIPE_CTRL_STAT_EN is defined.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int STAT_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] regfile_req_a_id,
    input  logic [REG_ADDR_W-1:0] regfile_req_b_id,
    input  logic                  use_a_id,
    input  logic                  use_b_id,
    input  logic [REG_ADDR_W-1:0] regfile_req_w_id_ex,
    input  logic                  memtoreg_id_ex,
    input  logic                  predict_fail,
    input  logic                  syscall_halt,
    input  logic                  resume,
    input  logic                  dm_req,
    input  logic                  dm_ack,
    output logic                  pc_en,
    output logic                  if_id_en,
    output logic                  id_ex_en,
    output logic                  ex_dm_en,
    output logic                  dm_wb_en,
    output logic                  if_id_flush,
    output logic                  id_ex_flush,
    output logic                  dm_wb_flush,
    output logic                  load_use,
    output logic                  halted,
    output logic [STATE_W-1:0]    state,
    output logic [STAT_W-1:0]     stall_cycles,
    output logic [STAT_W-1:0]     flush_count
);

    state_e r_state;
    state_e w_next_state;
    logic   w_hazard;
    logic   w_mem_stall;
    logic   w_flush_evt;

    hazard_detect u_hazard_detect (
        .regfile_req_a_id    (regfile_req_a_id),
        .regfile_req_b_id    (regfile_req_b_id),
        .use_a_id            (use_a_id),
        .use_b_id            (use_b_id),
        .regfile_req_w_id_ex (regfile_req_w_id_ex),
        .memtoreg_id_ex      (memtoreg_id_ex),
        .o_hazard            (w_hazard)
    );

    assign w_mem_stall = dm_req & ~dm_ack;
    assign state       = r_state;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and output decode; everything held at zero while reset is asserted
    always_comb begin
        w_next_state = r_state;
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_ex_en     = 1'b0;
        ex_dm_en     = 1'b0;
        dm_wb_en     = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        dm_wb_flush  = 1'b0;
        load_use     = 1'b0;
        halted       = 1'b0;
        w_flush_evt  = 1'b0;
        if (rst) begin
            w_next_state = ST_RUN;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_mem_stall) begin
                        dm_wb_en     = 1'b1;
                        dm_wb_flush  = 1'b1;
                        w_next_state = ST_MEM_WAIT;
                    end else if (syscall_halt) begin
                        w_next_state = ST_HALT;
                    end else if (predict_fail) begin
                        {pc_en, if_id_en, id_ex_en, ex_dm_en, dm_wb_en} = 5'b11111;
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                        w_flush_evt = 1'b1;
                    end else if (w_hazard) begin
                        // Hold PC and IF/ID, push one bubble into EX
                        id_ex_en    = 1'b1;
                        ex_dm_en    = 1'b1;
                        dm_wb_en    = 1'b1;
                        id_ex_flush = 1'b1;
                        load_use    = 1'b1;
                    end else begin
                        {pc_en, if_id_en, id_ex_en, ex_dm_en, dm_wb_en} = 5'b11111;
                    end
                end
                ST_MEM_WAIT: begin
                    if (dm_ack) begin
                        {pc_en, if_id_en, id_ex_en, ex_dm_en, dm_wb_en} = 5'b11111;
                        w_next_state = ST_RUN;
                    end else begin
                        dm_wb_en    = 1'b1;
                        dm_wb_flush = 1'b1;
                    end
                end
                ST_HALT: begin
                    halted = 1'b1;
                    if (resume) begin
                        {pc_en, if_id_en, id_ex_en, ex_dm_en, dm_wb_en} = 5'b11111;
                        w_next_state = ST_RUN;
                    end else begin
                        w_next_state = ST_HALT;
                    end
                end
                ST_BAD: begin
                    w_next_state = ST_RUN;
                end
                default: begin
                    w_next_state = ST_RUN;
                end
            endcase
        end
    end

`ifdef PIPE_CTRL_STAT_EN
    logic [STAT_W-1:0] r_stall_cycles;
    logic [STAT_W-1:0] r_flush_count;

    // Saturating statistics counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cycles <= {STAT_W{1'b0}};
            r_flush_count  <= {STAT_W{1'b0}};
        end else begin
            if ((load_use || (r_state == ST_MEM_WAIT)) && (r_stall_cycles != {STAT_W{1'b1}})) begin
                r_stall_cycles <= r_stall_cycles + {{(STAT_W-1){1'b0}}, 1'b1};
            end
            if (w_flush_evt && (r_flush_count != {STAT_W{1'b1}})) begin
                r_flush_count <= r_flush_count + {{(STAT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_count  = r_flush_count;
`else
    assign stall_cycles = {STAT_W{1'b0}};
    assign flush_count  = {STAT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl; counter expectations follow PIPE_CTRL_STAT_EN.
module tb_pipeline_hazard_ctrl;

`ifdef PIPE_CTRL_STAT_EN
    localparam int STAT_ON = 1;
`else
    localparam int STAT_ON = 0;
`endif

    // ctl = {pc,if_id,id_ex,ex_dm,dm_wb enables, if_id,id_ex,dm_wb flushes, load_use, halted, state}
    localparam logic [11:0] C_RST     = 12'b0;
    localparam logic [11:0] C_RUN     = {5'b11111, 3'b000, 2'b00, 2'b00};
    localparam logic [11:0] C_FRZ_RUN = {5'b00001, 3'b001, 2'b00, 2'b00};
    localparam logic [11:0] C_FRZ_MW  = {5'b00001, 3'b001, 2'b00, 2'b01};
    localparam logic [11:0] C_ACK     = {5'b11111, 3'b000, 2'b00, 2'b01};
    localparam logic [11:0] C_HALT_GO = {5'b00000, 3'b000, 2'b00, 2'b00};
    localparam logic [11:0] C_HALT    = {5'b00000, 3'b000, 2'b01, 2'b10};
    localparam logic [11:0] C_RESUME  = {5'b11111, 3'b000, 2'b01, 2'b10};
    localparam logic [11:0] C_PF      = {5'b11111, 3'b110, 2'b00, 2'b00};
    localparam logic [11:0] C_LU      = {5'b00111, 3'b010, 2'b10, 2'b00};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  regfile_req_a_id = 5'd0, regfile_req_b_id = 5'd0, regfile_req_w_id_ex = 5'd0;
    logic        use_a_id = 1'b0, use_b_id = 1'b0, memtoreg_id_ex = 1'b0;
    logic        predict_fail = 1'b0, syscall_halt = 1'b0, resume = 1'b0;
    logic        dm_req = 1'b0, dm_ack = 1'b0;
    logic        pc_en, if_id_en, id_ex_en, ex_dm_en, dm_wb_en;
    logic        if_id_flush, id_ex_flush, dm_wb_flush, load_use, halted;
    logic [1:0]  state;
    logic [31:0] stall_cycles, flush_count;
    logic [11:0] ctl;

    int n_checks = 0;
    int n_errors = 0;
    int exp_stall = 0;
    int exp_flush = 0;

    assign ctl = {pc_en, if_id_en, id_ex_en, ex_dm_en, dm_wb_en,
                  if_id_flush, id_ex_flush, dm_wb_flush, load_use, halted, state};

    pipeline_hazard_ctrl #(.STAT_W(32)) dut (
        .clk(clk), .rst(rst),
        .regfile_req_a_id(regfile_req_a_id), .regfile_req_b_id(regfile_req_b_id),
        .use_a_id(use_a_id), .use_b_id(use_b_id),
        .regfile_req_w_id_ex(regfile_req_w_id_ex), .memtoreg_id_ex(memtoreg_id_ex),
        .predict_fail(predict_fail), .syscall_halt(syscall_halt), .resume(resume),
        .dm_req(dm_req), .dm_ack(dm_ack),
        .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_dm_en(ex_dm_en), .dm_wb_en(dm_wb_en),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .dm_wb_flush(dm_wb_flush),
        .load_use(load_use), .halted(halted), .state(state),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        regfile_req_a_id = 5'd0; regfile_req_b_id = 5'd0; regfile_req_w_id_ex = 5'd0;
        use_a_id = 1'b0; use_b_id = 1'b0; memtoreg_id_ex = 1'b0;
        predict_fail = 1'b0; syscall_halt = 1'b0; resume = 1'b0;
        dm_req = 1'b0; dm_ack = 1'b0;
    endtask

    task automatic set_hazard(input logic [4:0] a, input logic [4:0] b, input logic ua,
                              input logic ub, input logic [4:0] w);
        regfile_req_a_id = a; regfile_req_b_id = b; use_a_id = ua; use_b_id = ub;
        regfile_req_w_id_ex = w; memtoreg_id_ex = 1'b1;
    endtask

    task automatic test_reset();
        tick();
        n_checks++;
        if (ctl !== C_RST || stall_cycles !== 32'd0 || flush_count !== 32'd0) begin
            n_errors++;
            $display("FAIL reset_hold: ctl=%b stall=%0d flush=%0d, expected ctl=%b 0 0", ctl, stall_cycles, flush_count, C_RST);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (ctl !== C_RUN) begin
            n_errors++;
            $display("FAIL reset_release: ctl=%b expected %b", ctl, C_RUN);
        end
    endtask

    task automatic test_mem_wait();
        logic [11:0] exp_seq [4];
        exp_seq = '{C_FRZ_RUN, C_FRZ_MW, C_FRZ_MW, C_ACK};
        dm_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            dm_ack = (i == 3) ? 1'b1 : 1'b0;
            #1;
            n_checks++;
            if (ctl !== exp_seq[i]) begin
                n_errors++;
                $display("FAIL mem_wait_cyc%0d: ctl=%b expected %b", i, ctl, exp_seq[i]);
            end
            tick();
        end
        clear_inputs();
        #1;
        exp_stall += 3 * STAT_ON;
        n_checks++;
        if (ctl !== C_RUN || stall_cycles !== 32'(exp_stall)) begin
            n_errors++;
            $display("FAIL mem_wait_done: ctl=%b stall=%0d expected %b %0d", ctl, stall_cycles, C_RUN, exp_stall);
        end
    endtask

    task automatic test_load_use();
        set_hazard(5'd3, 5'd7, 1'b1, 1'b0, 5'd3);
        #1;
        n_checks++;
        if (ctl !== C_LU) begin
            n_errors++;
            $display("FAIL lu_r3: ctl=%b expected %b", ctl, C_LU);
        end
        tick();
        exp_stall += STAT_ON;
        memtoreg_id_ex = 1'b0; regfile_req_w_id_ex = 5'd0;
        #1;
        n_checks++;
        if (ctl !== C_RUN) begin
            n_errors++;
            $display("FAIL lu_one_bubble: ctl=%b expected %b", ctl, C_RUN);
        end
        set_hazard(5'd0, 5'd0, 1'b1, 1'b1, 5'd0);
        #1;
        n_checks++;
        if (ctl !== C_RUN) begin
            n_errors++;
            $display("FAIL lu_r0: ctl=%b expected %b", ctl, C_RUN);
        end
        set_hazard(5'd9, 5'd9, 1'b0, 1'b0, 5'd9);
        #1;
        n_checks++;
        if (ctl !== C_RUN) begin
            n_errors++;
            $display("FAIL lu_unused_src: ctl=%b expected %b", ctl, C_RUN);
        end
        set_hazard(5'd1, 5'd31, 1'b1, 1'b1, 5'd31);
        #1;
        n_checks++;
        if (ctl !== C_LU) begin
            n_errors++;
            $display("FAIL lu_src_b: ctl=%b expected %b", ctl, C_LU);
        end
        tick();
        exp_stall += STAT_ON;
        clear_inputs();
        #1;
        n_checks++;
        if (stall_cycles !== 32'(exp_stall)) begin
            n_errors++;
            $display("FAIL lu_stall_count: stall=%0d expected %0d", stall_cycles, exp_stall);
        end
    endtask

    task automatic test_predict_fail();
        set_hazard(5'd3, 5'd0, 1'b1, 1'b0, 5'd3);
        predict_fail = 1'b1;
        #1;
        n_checks++;
        if (ctl !== C_PF) begin
            n_errors++;
            $display("FAIL pf_over_lu: ctl=%b expected %b", ctl, C_PF);
        end
        tick();
        exp_flush += STAT_ON;
        clear_inputs();
        #1;
        n_checks++;
        if (flush_count !== 32'(exp_flush) || stall_cycles !== 32'(exp_stall)) begin
            n_errors++;
            $display("FAIL pf_count: flush=%0d stall=%0d expected %0d %0d", flush_count, stall_cycles, exp_flush, exp_stall);
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] exp_seq [5];
        exp_seq = '{C_FRZ_RUN, C_ACK, C_HALT_GO, C_HALT, C_RESUME};
        set_hazard(5'd4, 5'd0, 1'b1, 1'b0, 5'd4);
        predict_fail = 1'b1; syscall_halt = 1'b1; dm_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            dm_ack = (i == 1) ? 1'b1 : 1'b0;
            if (i >= 2) dm_req = 1'b0;
            resume = (i == 4) ? 1'b1 : 1'b0;
            #1;
            n_checks++;
            if (ctl !== exp_seq[i]) begin
                n_errors++;
                $display("FAIL b2b_cyc%0d: ctl=%b expected %b", i, ctl, exp_seq[i]);
            end
            tick();
        end
        exp_stall += STAT_ON;
        resume = 1'b0; syscall_halt = 1'b0;
        #1;
        n_checks++;
        if (ctl !== C_PF) begin
            n_errors++;
            $display("FAIL b2b_pf_kept: ctl=%b expected %b", ctl, C_PF);
        end
        tick();
        exp_flush += STAT_ON;
        clear_inputs();
        #1;
        n_checks++;
        if (ctl !== C_RUN || flush_count !== 32'(exp_flush) || stall_cycles !== 32'(exp_stall)) begin
            n_errors++;
            $display("FAIL b2b_end: ctl=%b flush=%0d stall=%0d expected %b %0d %0d",
                     ctl, flush_count, stall_cycles, C_RUN, exp_flush, exp_stall);
        end
    endtask

    task automatic test_halt();
        syscall_halt = 1'b1;
        #1;
        n_checks++;
        if (ctl !== C_HALT_GO) begin
            n_errors++;
            $display("FAIL halt_enter: ctl=%b expected %b", ctl, C_HALT_GO);
        end
        tick();
        syscall_halt = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            n_checks++;
            if (ctl !== C_HALT) begin
                n_errors++;
                $display("FAIL halt_idle%0d: ctl=%b expected %b", i, ctl, C_HALT);
            end
            tick();
        end
        resume = 1'b1;
        #1;
        n_checks++;
        if (ctl !== C_RESUME) begin
            n_errors++;
            $display("FAIL halt_resume: ctl=%b expected %b", ctl, C_RESUME);
        end
        tick();
        #1;
        n_checks++;
        if (ctl !== C_RUN) begin
            n_errors++;
            $display("FAIL resume_in_run: ctl=%b expected %b", ctl, C_RUN);
        end
        tick();
        resume = 1'b0;
    endtask

    task automatic test_reset_mid_wait();
        dm_req = 1'b1;
        tick();
        tick();
        #1;
        n_checks++;
        if (ctl !== C_FRZ_MW) begin
            n_errors++;
            $display("FAIL rst_pre_wait: ctl=%b expected %b", ctl, C_FRZ_MW);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (ctl !== C_RST || stall_cycles !== 32'd0 || flush_count !== 32'd0) begin
            n_errors++;
            $display("FAIL rst_async: ctl=%b stall=%0d flush=%0d expected %b 0 0", ctl, stall_cycles, flush_count, C_RST);
        end
        tick();
        dm_req = 1'b0;
        rst = 1'b0;
        #1;
        n_checks++;
        if (ctl !== C_RUN) begin
            n_errors++;
            $display("FAIL rst_release_run: ctl=%b expected %b", ctl, C_RUN);
        end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_mem_wait();
        test_load_use();
        test_predict_fail();
        test_back_to_back();
        test_halt();
        test_reset_mid_wait();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
